// File: rtl/fetch_xmit.sv
// Fetch-side transmitter: sequential I-cache requests, in-order response queue, FE1 valid/ready to decode.
// Optional macro FE_STALL_CNT_EN adds fe_stall_cnt / fe_empty_cnt performance counters.
package fetch_xmit_pkg;
   typedef logic [31:0] t_paddr;
   typedef logic [31:0] t_rv_instr;

   typedef struct packed {
      logic valid;
      logic nuke_fe;
   } t_nuke_pkt;

   typedef struct packed {
      t_rv_instr   instr;
      t_paddr      pc;
      t_paddr      pc_nxt;
`ifdef SIMULATION
      logic [31:0] SIMID;
`endif
   } t_instr_pkt;
endpackage

module fetch_xmit
   import fetch_xmit_pkg::*;
#(
   parameter int     DEPTH       = 4,
   parameter t_paddr RESET_PC    = 32'h0000_0000,
   parameter int     INSTR_BYTES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  t_nuke_pkt  nuke_rb1,
   input  logic       resume_fetch_rbx,
   input  t_paddr     resume_pc_rbx,
   output logic       icache_req_valid,
   output t_paddr     icache_req_pc,
   input  logic       icache_req_ready,
   input  logic       icache_rsp_valid,
   input  t_rv_instr  icache_rsp_instr,
   input  logic       decode_ready_de0,
   output logic       valid_fe1,
   output t_instr_pkt instr_fe1
`ifdef FE_STALL_CNT_EN
   ,
   output logic [31:0] fe_stall_cnt,
   output logic [31:0] fe_empty_cnt
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {RUN, WAIT_RESUME} t_state;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   t_state          state_q, state_d;
   t_paddr          pc_q, pc_d;
   logic [CW-1:0]   outst_q, outst_d;
   logic [CW-1:0]   drop_q, drop_d;
   t_paddr          pcf_mem_q [DEPTH];
   t_paddr          pcf_mem_d [DEPTH];
   logic [PW-1:0]   pcf_wr_q, pcf_wr_d;
   logic [PW-1:0]   pcf_rd_q, pcf_rd_d;
   t_instr_pkt      q_mem_q [DEPTH];
   t_instr_pkt      q_mem_d [DEPTH];
   logic [PW-1:0]   q_head_q, q_head_d;
   logic [PW-1:0]   q_tail_q, q_tail_d;
   logic [CW-1:0]   q_cnt_q, q_cnt_d;
`ifdef SIMULATION
   logic [31:0]     simid_q, simid_d;
`endif

   logic            nuke;
   logic            credit_ok;
   logic            req_acc;
   logic            xfer;
   logic            rsp_drop;
   logic            rsp_push;
   t_paddr          rsp_pc;
   t_instr_pkt      rsp_pkt;

   assign nuke      = nuke_rb1.valid & nuke_rb1.nuke_fe;
   // Queue entries plus in-flight requests never exceed DEPTH, so responses always have a slot.
   assign credit_ok = ((CW+1)'(q_cnt_q) + (CW+1)'(outst_q)) < (CW+1)'(DEPTH);

   assign icache_req_valid = ~reset & (state_q == RUN) & ~nuke & credit_ok;
   assign icache_req_pc    = pc_q;
   assign valid_fe1        = ~reset & (state_q == RUN) & (q_cnt_q != '0);
   assign instr_fe1        = q_mem_q[q_head_q];

   always_comb begin
      req_acc   = icache_req_valid & icache_req_ready;
      xfer      = valid_fe1 & decode_ready_de0;
      rsp_drop  = icache_rsp_valid & (nuke | (drop_q != '0));
      rsp_push  = icache_rsp_valid & ~rsp_drop;
      rsp_pc    = pcf_mem_q[pcf_rd_q];

      rsp_pkt        = '0;
      rsp_pkt.instr  = icache_rsp_instr;
      rsp_pkt.pc     = rsp_pc;
      rsp_pkt.pc_nxt = rsp_pc + t_paddr'(INSTR_BYTES);
`ifdef SIMULATION
      rsp_pkt.SIMID  = simid_q;
      simid_d        = simid_q;
`endif

      state_d   = state_q;
      pc_d      = pc_q;
      outst_d   = outst_q;
      drop_d    = drop_q;
      pcf_mem_d = pcf_mem_q;
      pcf_wr_d  = pcf_wr_q;
      pcf_rd_d  = pcf_rd_q;
      q_mem_d   = q_mem_q;
      q_head_d  = q_head_q;
      q_tail_d  = q_tail_q;
      q_cnt_d   = q_cnt_q;

      // Nuke takes priority over a resume in the same cycle.
      if (nuke) begin
         state_d = WAIT_RESUME;
      end else if ((state_q == WAIT_RESUME) && resume_fetch_rbx) begin
         state_d = RUN;
         pc_d    = resume_pc_rbx;
      end

      if (req_acc) begin
         pc_d                = pc_q + t_paddr'(INSTR_BYTES);
         pcf_mem_d[pcf_wr_q] = pc_q;
         pcf_wr_d            = ptr_inc(pcf_wr_q);
      end
      if (icache_rsp_valid) begin
         pcf_rd_d = ptr_inc(pcf_rd_q);
      end
      outst_d = outst_q + CW'(req_acc) - CW'(icache_rsp_valid);

      if (nuke) begin
         drop_d = outst_q - CW'(icache_rsp_valid);
      end else if (icache_rsp_valid && (drop_q != '0)) begin
         drop_d = drop_q - 1'b1;
      end

      if (nuke) begin
         q_head_d = '0;
         q_tail_d = '0;
         q_cnt_d  = '0;
      end else begin
         if (rsp_push) begin
            q_mem_d[q_tail_q] = rsp_pkt;
            q_tail_d          = ptr_inc(q_tail_q);
`ifdef SIMULATION
            simid_d           = simid_q + 32'd1;
`endif
         end
         if (xfer) begin
            q_head_d = ptr_inc(q_head_q);
         end
         q_cnt_d = q_cnt_q + CW'(rsp_push) - CW'(xfer);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
         pcf_wr_q <= '0;
         pcf_rd_q <= '0;
         q_head_q <= '0;
         q_tail_q <= '0;
         q_cnt_q  <= '0;
`ifdef SIMULATION
         simid_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
         pcf_wr_q <= pcf_wr_d;
         pcf_rd_q <= pcf_rd_d;
         q_head_q <= q_head_d;
         q_tail_q <= q_tail_d;
         q_cnt_q  <= q_cnt_d;
`ifdef SIMULATION
         simid_q  <= simid_d;
`endif
      end
   end

   // Storage arrays carry no reset; pointers and counts qualify their contents.
   always_ff @(posedge clk) begin
      pcf_mem_q <= pcf_mem_d;
      q_mem_q   <= q_mem_d;
   end

`ifdef FE_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] empty_cnt_q, empty_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      empty_cnt_d = empty_cnt_q;
      if (valid_fe1 && !decode_ready_de0 && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if ((state_q == RUN) && (q_cnt_q == '0) && (empty_cnt_q != 32'hFFFF_FFFF)) begin
         empty_cnt_d = empty_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         empty_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         empty_cnt_q <= empty_cnt_d;
      end
   end

   assign fe_stall_cnt = stall_cnt_q;
   assign fe_empty_cnt = empty_cnt_q;
`endif

`ifdef ASSERT
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(rsp_push && (q_cnt_q == CW'(DEPTH)) && !xfer));
         assert (!(icache_rsp_valid && (outst_q == '0)));
      end
   end
`endif

endmodule
